pattern_scan_ctrl: RTL

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

---
 rtl/pattern_scan_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: walks a PW-bit pattern across a latched DW-bit word,
// LSB first, counting matches and recording the lowest matching position.
// Only PW < DW is supported.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; results from the last scan are held
// SCAN  | one window compare per cycle, pos walking upward
// DONE  | single-cycle completion pulse, then back to IDLE
module pattern_scan_ctrl #(
  parameter int DW = 32,
  parameter int PW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_overlap,
  input  logic [DW-1:0] i_data_in,
  input  logic [PW-1:0] i_pat_in,
  output logic          o_busy,
  output logic          o_done,
  output logic [4:0]    o_match_cnt,
  output logic          o_found,
  output logic [4:0]    o_first_pos
);

  localparam int POSW = $clog2(DW + 1);
  localparam logic [POSW:0] LAST_POS = (POSW+1)'(DW - PW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [DW-1:0]   r_data_q;
  logic [PW-1:0]   r_pat_q;
  logic            r_ovl_q;
  logic [POSW-1:0] r_pos;
  logic [4:0]      r_match_cnt;
  logic            r_found;
  logic [4:0]      r_first_pos;

  logic [PW-1:0]   w_window;
  logic            w_hit;
  logic [POSW:0]   w_pos_sum;
  logic            w_last;
  logic            w_accept;

  // Window under test and the position the walk would move to next.
  // A non-overlapping match jumps past the whole matched window.
  assign w_window  = PW'(r_data_q >> r_pos);
  assign w_hit     = (w_window == r_pat_q);
  assign w_pos_sum = {1'b0, r_pos} + ((w_hit && !r_ovl_q) ? (POSW+1)'(PW) : (POSW+1)'(1));
  assign w_last    = (w_pos_sum > LAST_POS);

  // abort masks start so a simultaneous request is dropped.
  assign w_accept  = (r_state == ST_IDLE) && i_start && !i_abort;

  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_match_cnt = r_match_cnt;
  assign o_found     = r_found;
  assign o_first_pos = r_first_pos;

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand latch, position walk and result accumulation.
  // An aborted cycle does not compare, so partial results stay as they were.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_data_q    <= '0;
      r_pat_q     <= '0;
      r_ovl_q     <= 1'b0;
      r_pos       <= '0;
      r_match_cnt <= '0;
      r_found     <= 1'b0;
      r_first_pos <= '0;
    end else if (w_accept) begin
      r_data_q    <= i_data_in;
      r_pat_q     <= i_pat_in;
      r_ovl_q     <= i_overlap;
      r_pos       <= '0;
      r_match_cnt <= '0;
      r_found     <= 1'b0;
      r_first_pos <= '0;
    end else if ((r_state == ST_SCAN) && !i_abort) begin
      r_pos <= w_pos_sum[POSW-1:0];
      if (w_hit) begin
        if (r_match_cnt != 5'd31) begin
          r_match_cnt <= r_match_cnt + 5'd1;
        end
        if (!r_found) begin
          r_found     <= 1'b1;
          r_first_pos <= 5'(r_pos);
        end
      end
    end
  end

endmodule
